// File: rtl/dac_pkg.sv
// Shared types and constants for the outbound serial DAC path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   DAC_FRAME_W      bits per DAC frame (addr[1:0], rng, code[7:0])
//   dac_state_t      transmitter FSM states
//   DAC_ADDR_DEF     default channel select
//   DAC_RNG_DEF      default range bit
//   dac_frame()      assembles the 11-bit frame, MSB sent first
package dac_pkg;

  localparam int DAC_FRAME_W = 11;

  localparam logic [1:0] DAC_ADDR_DEF = 2'b00;
  localparam logic       DAC_RNG_DEF  = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    LOAD,
    UPDATE,
    GAP
  } dac_state_t;

  function automatic logic [DAC_FRAME_W-1:0] dac_frame(
    input logic [1:0] addr,
    input logic       rng,
    input logic [7:0] code
  );
    return {addr, rng, code};
  endfunction

endpackage

// File: rtl/dac_clk_div.sv
// Phase timer for the DAC serial clock: one-cycle phase_tick every CLK_DIV clk cycles.
// Latency: first tick CLK_DIV-1 cycles after the restart edge, then every CLK_DIV cycles.
// Backpressure: none; free-running, realigned by restart.
//
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   restart      realigns the counter so the next tick lands CLK_DIV cycles later
//   phase_tick   high during the last cycle of each phase
module dac_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic phase_tick
);

  localparam int             CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || (cnt == CNT_LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // With CLK_DIV=1 the counter sits at 0 and every cycle is a tick.
  assign phase_tick = (cnt == CNT_LAST);

endmodule

// File: rtl/dac_serial_tx.sv
// Serial transmitter for a TLC5620-style 8-bit DAC: 11-bit frame, then LOAD and LDAC strobes.
// Latency: 25*CLK_DIV cycles per frame from transfer edge to next accepted sample.
// Backpressure: sample_ready low for the whole frame; valid while busy is ignored, not queued.
//
// Ports:
//   clk, reset                 system clock, asynchronous active-high reset
//   sample_data/valid/ready    one 8-bit DAC code per handshake
//   dac_clk, dac_data          serial clock and MSB-first data (DAC samples on dac_clk fall)
//   dac_load_n, dac_ldac_n     active-low frame latch and output update strobes
//   busy                       frame in progress (== !sample_ready)
//   frames_sent                wrapping count of completed frames
module dac_serial_tx
  import dac_pkg::*;
#(
  parameter int         CLK_DIV  = 4,
  parameter logic [1:0] DAC_ADDR = DAC_ADDR_DEF,
  parameter logic       DAC_RNG  = DAC_RNG_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  sample_data,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        dac_clk,
  output logic        dac_data,
  output logic        dac_load_n,
  output logic        dac_ldac_n,
  output logic        busy,
  output logic [15:0] frames_sent
);

  localparam logic [3:0] BIT_LAST = 4'(DAC_FRAME_W - 1);

  dac_state_t             state, state_nxt;
  logic [DAC_FRAME_W-1:0] shreg, shreg_nxt;
  logic [3:0]             bit_cnt, bit_cnt_nxt;
  logic                   clk_q, clk_nxt;
  logic                   data_q, data_nxt;
  logic                   load_n_q, load_n_nxt;
  logic                   ldac_n_q, ldac_n_nxt;
  logic [15:0]            frames_q, frames_nxt;

  logic phase_tick;
  logic transfer;

  dac_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk        (clk),
    .reset      (reset),
    .restart    (transfer),
    .phase_tick (phase_tick)
  );

  // Ready is also raised in the last GAP cycle so a producer already holding
  // valid is taken on the edge that ends GAP: no idle cycle between frames.
  // It decodes registered state only, so nothing from the inputs reaches it.
  assign sample_ready = (state == IDLE) || ((state == GAP) && phase_tick);
  assign busy         = !sample_ready;
  assign transfer     = sample_valid && sample_ready;

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    clk_nxt     = clk_q;
    data_nxt    = data_q;
    load_n_nxt  = load_n_q;
    ldac_n_nxt  = ldac_n_q;
    frames_nxt  = frames_q;

    case (state)
      IDLE: begin
      end
      SHIFT: begin
        // dac_clk itself marks the phase: high = phase H, low = phase L.
        if (phase_tick) begin
          if (clk_q) begin
            clk_nxt = 1'b0;
          end else if (bit_cnt == BIT_LAST) begin
            state_nxt  = LOAD;
            load_n_nxt = 1'b0;
          end else begin
            // Data only moves at the start of phase H, giving a full phase of
            // setup and hold around the falling edge.
            bit_cnt_nxt = bit_cnt + 4'd1;
            clk_nxt     = 1'b1;
            data_nxt    = shreg[DAC_FRAME_W-2];
            shreg_nxt   = {shreg[DAC_FRAME_W-2:0], 1'b0};
          end
        end
      end
      LOAD: begin
        if (phase_tick) begin
          state_nxt  = UPDATE;
          load_n_nxt = 1'b1;
          ldac_n_nxt = 1'b0;
        end
      end
      UPDATE: begin
        if (phase_tick) begin
          state_nxt  = GAP;
          ldac_n_nxt = 1'b1;
          frames_nxt = frames_q + 16'd1;
        end
      end
      GAP: begin
        if (phase_tick) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // A transfer (from IDLE or the final GAP cycle) starts bit 10's phase H.
    if (transfer) begin
      state_nxt   = SHIFT;
      shreg_nxt   = dac_frame(DAC_ADDR, DAC_RNG, sample_data);
      bit_cnt_nxt = 4'd0;
      clk_nxt     = 1'b1;
      data_nxt    = DAC_ADDR[1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= 4'd0;
      clk_q    <= 1'b0;
      data_q   <= 1'b0;
      load_n_q <= 1'b1;
      ldac_n_q <= 1'b1;
      frames_q <= 16'd0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      clk_q    <= clk_nxt;
      data_q   <= data_nxt;
      load_n_q <= load_n_nxt;
      ldac_n_q <= ldac_n_nxt;
      frames_q <= frames_nxt;
    end
  end

  assign dac_clk     = clk_q;
  assign dac_data    = data_q;
  assign dac_load_n  = load_n_q;
  assign dac_ldac_n  = ldac_n_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_dac_serial_tx.sv
// Directed bench for dac_serial_tx at CLK_DIV=4 and CLK_DIV=1.
// Cycle n means the interval right after transfer edge T+n.
module tb_dac_serial_tx;

  logic clk;
  logic reset;

  logic [7:0]  s4_data, s1_data;
  logic        s4_valid, s1_valid;
  logic        d4_ready, d4_clk, d4_data, d4_load, d4_ldac, d4_busy;
  logic        d1_ready, d1_clk, d1_data, d1_load, d1_ldac, d1_busy;
  logic [15:0] d4_frames, d1_frames;

  int vectors;
  int miscompares;

  dac_serial_tx #(.CLK_DIV(4)) u_dut4 (
    .clk          (clk),
    .reset        (reset),
    .sample_data  (s4_data),
    .sample_valid (s4_valid),
    .sample_ready (d4_ready),
    .dac_clk      (d4_clk),
    .dac_data     (d4_data),
    .dac_load_n   (d4_load),
    .dac_ldac_n   (d4_ldac),
    .busy         (d4_busy),
    .frames_sent  (d4_frames)
  );

  dac_serial_tx #(.CLK_DIV(1)) u_dut1 (
    .clk          (clk),
    .reset        (reset),
    .sample_data  (s1_data),
    .sample_valid (s1_valid),
    .sample_ready (d1_ready),
    .dac_clk      (d1_clk),
    .dac_data     (d1_data),
    .dac_load_n   (d1_load),
    .dac_ldac_n   (d1_ldac),
    .busy         (d1_busy),
    .frames_sent  (d1_frames)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-frame observations of the CLK_DIV=4 instance.
  logic [10:0] w_bits;
  int          w_load_first, w_load_cnt, w_ldac_first, w_ldac_cnt, w_clk_err;
  logic        w_rdy98, w_rdy99;
  logic [15:0] w_fr95, w_fr96;

  // Called at cycle n=0; returns at cycle n=99.
  task automatic watch4(input bit keep_valid, input logic [7:0] next_d,
                        input int pulse_n, input logic [7:0] pulse_d);
    w_bits = '0;
    w_load_first = -1; w_load_cnt = 0;
    w_ldac_first = -1; w_ldac_cnt = 0;
    w_clk_err = 0;
    for (int n = 0; n < 100; n++) begin
      if (n == 0) begin
        if (keep_valid) s4_data = next_d;
        else s4_valid = 1'b0;
      end
      if (pulse_n >= 0 && n == pulse_n) begin
        s4_valid = 1'b1;
        s4_data  = pulse_d;
      end
      if (pulse_n >= 0 && n == pulse_n + 1) s4_valid = 1'b0;
      if (d4_clk !== ((n < 88) && ((n % 8) < 4))) w_clk_err++;
      // Last cycle of phase H: the value the DAC takes on the falling edge.
      if ((n < 88) && ((n % 8) == 3)) w_bits = {w_bits[9:0], d4_data};
      if (d4_load === 1'b0) begin
        if (w_load_first < 0) w_load_first = n;
        w_load_cnt++;
      end
      if (d4_ldac === 1'b0) begin
        if (w_ldac_first < 0) w_ldac_first = n;
        w_ldac_cnt++;
      end
      if (n == 95) w_fr95 = d4_frames;
      if (n == 96) w_fr96 = d4_frames;
      if (n == 98) w_rdy98 = d4_ready;
      if (n == 99) w_rdy99 = d4_ready;
      if (n < 99) tick();
    end
  endtask

  initial begin
    logic [10:0] b1;
    int l1_first, l1_cnt, a1_first, a1_cnt, c1_err, r1_first, busy_cnt, load_cnt;
    logic [15:0] f1_23, f1_24;

    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    s4_valid = 1'b0; s4_data = 8'h00;
    s1_valid = 1'b0; s1_data = 8'h00;

    // Reset values: {ready, busy, dac_clk, dac_data, load_n, ldac_n}
    #2;
    chk("reset_outputs", {d4_ready, d4_busy, d4_clk, d4_data, d4_load, d4_ldac}, 6'b100011);
    chk("reset_frames", d4_frames, 16'h0000);
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Single frame 0xA5: frame = 000_1010_0101
    s4_data = 8'hA5; s4_valid = 1'b1;
    tick();
    chk("a5_start", {d4_busy, d4_clk, d4_data}, 3'b110);
    watch4(1'b0, 8'h00, -1, 8'h00);
    chk("a5_bits", w_bits, 11'h0A5);
    chk("a5_clk_pattern_err", w_clk_err, 0);
    chk("a5_load_first", w_load_first, 88);
    chk("a5_load_len", w_load_cnt, 4);
    chk("a5_ldac_first", w_ldac_first, 92);
    chk("a5_ldac_len", w_ldac_cnt, 4);
    chk("a5_ready_98", w_rdy98, 1'b0);
    chk("a5_ready_99", w_rdy99, 1'b1);
    chk("a5_frames_95", w_fr95, 16'd0);
    chk("a5_frames_96", w_fr96, 16'd1);
    tick();
    chk("a5_idle_ready", {d4_ready, d4_busy}, 2'b10);

    // Back-to-back 0x00 then 0xFF with valid held high
    s4_data = 8'h00; s4_valid = 1'b1;
    tick();
    watch4(1'b1, 8'hFF, -1, 8'h00);
    chk("b2b_first_bits", w_bits, 11'h000);
    chk("b2b_first_frames", w_fr96, 16'd2);
    chk("b2b_ready_99", w_rdy99, 1'b1);
    tick();  // edge T+100 must be the second transfer
    chk("b2b_second_start", {d4_busy, d4_clk, d4_data}, 3'b110);
    watch4(1'b0, 8'h00, -1, 8'h00);
    chk("b2b_second_bits", w_bits, 11'h0FF);
    chk("b2b_second_clk_err", w_clk_err, 0);
    chk("b2b_second_frames", w_fr96, 16'd3);

    // Valid pulsed mid-frame is dropped
    tick(); tick();
    s4_data = 8'h5A; s4_valid = 1'b1;
    tick();
    watch4(1'b0, 8'h00, 9, 8'h3C);
    chk("busy_frame_bits", w_bits, 11'h05A);
    chk("busy_frame_frames", w_fr96, 16'd4);
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (d4_busy !== 1'b0) busy_cnt++;
    end
    chk("busy_no_second_frame", busy_cnt, 0);
    chk("busy_frames_after", d4_frames, 16'd4);

    // Reset during bit 5 (cycles 40..47)
    s4_data = 8'h77; s4_valid = 1'b1;
    tick();
    s4_valid = 1'b0;
    repeat (42) tick();
    chk("mid_bit5_clk_high", {d4_busy, d4_clk}, 2'b11);
    reset = 1'b1;
    #1;
    chk("mid_reset_outputs", {d4_ready, d4_busy, d4_clk, d4_data, d4_load, d4_ldac}, 6'b100011);
    chk("mid_reset_frames", d4_frames, 16'h0000);
    load_cnt = 0;
    busy_cnt = 0;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (d4_load !== 1'b1) load_cnt++;
      if (d4_busy !== 1'b0) busy_cnt++;
    end
    chk("mid_no_load", load_cnt, 0);
    chk("mid_no_busy", busy_cnt, 0);
    s4_data = 8'h12; s4_valid = 1'b1;
    tick();
    watch4(1'b0, 8'h00, -1, 8'h00);
    chk("after_reset_bits", w_bits, 11'h012);
    chk("after_reset_load_first", w_load_first, 88);
    chk("after_reset_frames", w_fr96, 16'd1);

    // CLK_DIV=1: 25-cycle frame and frames_sent wrap
    force u_dut1.frames_q = 16'hFFFF;
    tick();
    release u_dut1.frames_q;
    tick();
    chk("fast_preload", d1_frames, 16'hFFFF);
    s1_data = 8'hC3; s1_valid = 1'b1;
    tick();
    s1_valid = 1'b0;
    b1 = '0;
    l1_first = -1; l1_cnt = 0; a1_first = -1; a1_cnt = 0; c1_err = 0; r1_first = -1;
    f1_23 = '0; f1_24 = '0;
    for (int n = 0; n < 25; n++) begin
      if (d1_clk !== ((n < 22) && ((n % 2) == 0))) c1_err++;
      if ((n < 22) && ((n % 2) == 0)) b1 = {b1[9:0], d1_data};
      if (d1_load === 1'b0) begin
        if (l1_first < 0) l1_first = n;
        l1_cnt++;
      end
      if (d1_ldac === 1'b0) begin
        if (a1_first < 0) a1_first = n;
        a1_cnt++;
      end
      if (d1_ready === 1'b1 && r1_first < 0) r1_first = n;
      if (n == 23) f1_23 = d1_frames;
      if (n == 24) f1_24 = d1_frames;
      if (n < 24) tick();
    end
    chk("fast_bits", b1, 11'h0C3);
    chk("fast_clk_err", c1_err, 0);
    chk("fast_load", {l1_first[7:0], l1_cnt[7:0]}, {8'd22, 8'd1});
    chk("fast_ldac", {a1_first[7:0], a1_cnt[7:0]}, {8'd23, 8'd1});
    chk("fast_ready_first", r1_first, 24);
    chk("fast_frames_before_gap", f1_23, 16'hFFFF);
    chk("fast_frames_wrap", f1_24, 16'h0000);
    tick();
    chk("fast_idle", {d1_ready, d1_busy, d1_frames}, {2'b10, 16'h0000});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
